// File: rtl/accum_feeder.sv
// accum_feeder: buffers a valid/ready element stream and feeds an accumulator (out_data/stg_en),
// idling stg_en for cfg_gap+1 cycles after each vector. Define ACC_FEED_STALL_CNT_EN for stall_cnt.
module accum_feeder #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned GAP_WIDTH  = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_last,
  input  logic [GAP_WIDTH-1:0]  cfg_gap,
  input  logic                  clr_err,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  stg_en,
  output logic                  vec_done,
  output logic                  busy,
  output logic                  err_underrun
`ifdef ACC_FEED_STALL_CNT_EN
  ,
  output logic [15:0]           stall_cnt
`endif
);

  localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam int unsigned ENT_W = DATA_WIDTH + 1;

  typedef enum logic [1:0] {IDLE, FEED, GAP} state_t;

  state_t                state, state_nxt;
  logic [ENT_W-1:0]      mem [FIFO_DEPTH];
  logic [PTR_W-1:0]      wr_ptr, rd_ptr;
  logic [CNT_W-1:0]      count, count_nxt;
  logic [GAP_WIDTH-1:0]  gap_cnt;
  logic                  push, pop, empty, rd_last, underrun;
  logic [DATA_WIDTH-1:0] rd_data;

  assign empty     = (count == '0);
  assign push      = in_valid & in_ready;
  assign pop       = !empty && (state != GAP);
  assign {rd_last, rd_data} = mem[rd_ptr];
  assign underrun  = (state == FEED) && empty;
  assign count_nxt = count + CNT_W'(push) - CNT_W'(pop);

  // Next state: a popped last element always ends the vector in GAP
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, FEED: if (!empty) state_nxt = rd_last ? GAP : FEED;
      GAP:        if (gap_cnt == '0) state_nxt = IDLE;
      default:    state_nxt = IDLE;
    endcase
  end

  // Element storage; contents need no reset since pointers/count define validity
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {in_last, in_data};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      gap_cnt      <= '0;
      in_ready     <= 1'b0;
      busy         <= 1'b0;
      out_data     <= '0;
      stg_en       <= 1'b0;
      vec_done     <= 1'b0;
      err_underrun <= 1'b0;
    end else begin
      state    <= state_nxt;
      count    <= count_nxt;
      in_ready <= (count_nxt != CNT_W'(FIFO_DEPTH));
      busy     <= (state_nxt != IDLE) || (count_nxt != '0);
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      stg_en   <= pop;
      vec_done <= pop && rd_last;
      if (pop) out_data <= rd_data;
      if (pop && rd_last) begin
        gap_cnt <= cfg_gap;
      end else if ((state == GAP) && (gap_cnt != '0)) begin
        gap_cnt <= gap_cnt - GAP_WIDTH'(1);
      end
      if (underrun) begin
        err_underrun <= 1'b1;
      end else if (clr_err) begin
        err_underrun <= 1'b0;
      end
    end
  end

`ifdef ACC_FEED_STALL_CNT_EN
  // Saturating count of starved FEED cycles; clear has priority
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
    end else if (clr_err) begin
      stall_cnt <= '0;
    end else if (underrun && (stall_cnt != 16'hFFFF)) begin
      stall_cnt <= stall_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_accum_feeder.sv
// Testbench for accum_feeder: directed table, hand-written corner sequences and
// randomized traffic checked against a queue-based reference model.
module tb_accum_feeder;

  localparam int unsigned DW    = 32;
  localparam int unsigned DEPTH = 4;

  logic          clk;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic          in_last;
  logic [3:0]    cfg_gap;
  logic          clr_err;
  logic [DW-1:0] out_data;
  logic          stg_en;
  logic          vec_done;
  logic          busy;
  logic          err_underrun;
`ifdef ACC_FEED_STALL_CNT_EN
  logic [15:0]   stall_cnt;
`endif

  accum_feeder #(.DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH), .GAP_WIDTH(4)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_data      (in_data),
    .in_last      (in_last),
    .cfg_gap      (cfg_gap),
    .clr_err      (clr_err),
    .out_data     (out_data),
    .stg_en       (stg_en),
    .vec_done     (vec_done),
    .busy         (busy),
    .err_underrun (err_underrun)
`ifdef ACC_FEED_STALL_CNT_EN
    ,
    .stall_cnt    (stall_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: element queue, gap countdown and a mid-vector flag
  typedef struct {
    logic [DW-1:0] data;
    logic          last;
  } ent_t;

  ent_t          m_q[$];
  int            m_gap;
  bit            m_mid;
  bit            m_ready;
  bit            m_stg;
  bit            m_vd;
  bit            m_busy;
  bit            m_err;
  int            m_stall;
  logic [DW-1:0] m_data;

  typedef struct {
    logic          vld;
    logic [DW-1:0] d;
    logic          lst;
    logic [3:0]    gap;
    logic          e_stg;
    logic [DW-1:0] e_data;
    logic          e_vd;
  } vec_t;

  vec_t tbl[9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    m_gap = 0; m_mid = 0; m_ready = 0; m_stg = 0; m_vd = 0;
    m_busy = 0; m_err = 0; m_stall = 0; m_data = '0;
  endtask

  task automatic model_edge();
    bit   pushing;
    bit   und;
    ent_t e;
    pushing = in_valid && m_ready;
    und = 0;
    m_stg = 0;
    m_vd = 0;
    if (m_gap > 0) begin
      m_gap--;
    end else if (m_q.size() > 0) begin
      e = m_q.pop_front();
      m_stg = 1;
      m_data = e.data;
      m_vd = e.last;
      if (e.last) begin
        m_gap = int'(cfg_gap) + 1;
        m_mid = 0;
      end else begin
        m_mid = 1;
      end
    end else if (m_mid) begin
      und = 1;
    end
    if (pushing) begin
      e.data = in_data;
      e.last = in_last;
      m_q.push_back(e);
    end
    m_err = und | (m_err & !clr_err);
    if (clr_err) m_stall = 0;
    else if (und && m_stall < 65535) m_stall++;
    m_ready = (m_q.size() < DEPTH);
    m_busy = (m_gap > 0) || m_mid || (m_q.size() > 0);
  endtask

  task automatic chk_model();
    chk("stg_en", stg_en, m_stg);
    chk("vec_done", vec_done, m_vd);
    chk("out_data", out_data, m_data);
    chk("in_ready", in_ready, m_ready);
    chk("busy", busy, m_busy);
    chk("err_underrun", err_underrun, m_err);
`ifdef ACC_FEED_STALL_CNT_EN
    chk("stall_cnt", 32'(stall_cnt), 32'(m_stall));
`endif
  endtask

  // One clock: advance the model with the current inputs, then sample at negedge
  task automatic step();
    if (rst_n) model_edge();
    else model_reset();
    @(posedge clk);
    @(negedge clk);
    chk_model();
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) step();
  endtask

  task automatic push_elem(input logic [DW-1:0] d, input logic l);
    bit acc;
    acc = 0;
    in_valid = 1'b1;
    in_data = d;
    in_last = l;
    for (int k = 0; k < 60; k++) begin
      acc = in_ready;
      step();
      if (acc) break;
    end
    chk("push_accept", 32'(acc), 32'd1);
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b1; in_data = 32'hdead_beef; in_last = 1'b0;
    cfg_gap = 4'd2; clr_err = 1'b0;
    model_reset();

    tbl[0] = '{1'b1, 32'd3,  1'b0, 4'd2, 1'b0, 32'd0,  1'b0};
    tbl[1] = '{1'b1, 32'd5,  1'b0, 4'd2, 1'b1, 32'd3,  1'b0};
    tbl[2] = '{1'b1, 32'd7,  1'b1, 4'd2, 1'b1, 32'd5,  1'b0};
    tbl[3] = '{1'b0, 32'd0,  1'b0, 4'd2, 1'b1, 32'd7,  1'b1};
    tbl[4] = '{1'b1, 32'd11, 1'b1, 4'd2, 1'b0, 32'd7,  1'b0};
    tbl[5] = '{1'b0, 32'd0,  1'b0, 4'd2, 1'b0, 32'd7,  1'b0};
    tbl[6] = '{1'b0, 32'd0,  1'b0, 4'd2, 1'b0, 32'd7,  1'b0};
    tbl[7] = '{1'b0, 32'd0,  1'b0, 4'd2, 1'b1, 32'd11, 1'b1};
    tbl[8] = '{1'b0, 32'd0,  1'b0, 4'd2, 1'b0, 32'd11, 1'b0};

    // T1: reset held with in_valid high
    @(negedge clk);
    repeat (3) step();
    chk("t1_ready_in_reset", in_ready, 1'b0);
    chk("t1_stg_in_reset", stg_en, 1'b0);
    chk("t1_data_in_reset", out_data, 32'd0);
    rst_n = 1'b1;
    step();
    chk("t1_ready_after_release", in_ready, 1'b1);
    in_valid = 1'b0;

    // T2: vector 3,5,7 then a second vector waiting out the gap
    for (int i = 0; i < 9; i++) begin
      in_valid = tbl[i].vld;
      in_data = tbl[i].d;
      in_last = tbl[i].lst;
      cfg_gap = tbl[i].gap;
      step();
      chk($sformatf("t2_row%0d_stg", i), stg_en, tbl[i].e_stg);
      chk($sformatf("t2_row%0d_data", i), out_data, tbl[i].e_data);
      chk($sformatf("t2_row%0d_vd", i), vec_done, tbl[i].e_vd);
    end
    idle(6);

    // T3: fill the FIFO while the output side sits in a long gap
    cfg_gap = 4'd15;
    push_elem(32'd100, 1'b1);
    for (int i = 0; i < 6; i++) begin
      push_elem(32'd200 + 32'(i), (i == 5));
      if (i == 3) chk("t3_ready_low_when_full", in_ready, 1'b0);
    end
    idle(40);
    chk("t3_last_out", out_data, 32'd205);
    chk("t3_idle_busy", busy, 1'b0);

    // T4: underrun across a 4-cycle hole, then clear
    cfg_gap = 4'd1;
    push_elem(32'd1, 1'b0);
    push_elem(32'd2, 1'b0);
    idle(4);
    chk("t4_stg_in_hole", stg_en, 1'b0);
    push_elem(32'd3, 1'b1);
    idle(2);
    chk("t4_err_set", err_underrun, 1'b1);
`ifdef ACC_FEED_STALL_CNT_EN
    chk("t4_stall_cnt", 32'(stall_cnt), 32'd4);
`endif
    clr_err = 1'b1;
    step();
    clr_err = 1'b0;
    chk("t4_err_cleared", err_underrun, 1'b0);
`ifdef ACC_FEED_STALL_CNT_EN
    chk("t4_stall_cleared", 32'(stall_cnt), 32'd0);
`endif
    idle(4);

    // T5: single-element vectors with cfg_gap=0
    cfg_gap = 4'd0;
    push_elem(32'd9, 1'b1);
    push_elem(32'd10, 1'b1);
    in_valid = 1'b0;
    chk("t5_stg", stg_en, 1'b1);
    chk("t5_data", out_data, 32'd9);
    chk("t5_vd", vec_done, 1'b1);
    step();
    chk("t5_gap_stg", stg_en, 1'b0);
    step();
    chk("t5_next_stg", stg_en, 1'b1);
    chk("t5_next_data", out_data, 32'd10);
    idle(4);

    // T6: reset while feeding with entries still queued
    cfg_gap = 4'd15;
    push_elem(32'd50, 1'b1);
    for (int i = 0; i < 4; i++) push_elem(32'd51 + 32'(i), 1'b0);
    in_valid = 1'b0;
    for (int k = 0; k < 60; k++) begin
      if (stg_en) break;
      step();
    end
    chk("t6_feeding", stg_en, 1'b1);
    rst_n = 1'b0;
    #1;
    model_reset();
    chk("t6_stg_async", stg_en, 1'b0);
    chk("t6_busy_async", busy, 1'b0);
    chk("t6_data_async", out_data, 32'd0);
    chk("t6_ready_async", in_ready, 1'b0);
    @(negedge clk);
    step();
    rst_n = 1'b1;
    step();
    chk("t6_ready_release", in_ready, 1'b1);
    idle(6);
    chk("t6_fifo_empty", busy, 1'b0);

    // Randomized traffic against the model
    for (int c = 0; c < 2000; c++) begin
      in_valid = ($urandom_range(0, 9) < 7);
      in_data = $urandom;
      in_last = ($urandom_range(0, 3) == 0);
      cfg_gap = 4'($urandom_range(0, 4));
      clr_err = ($urandom_range(0, 19) == 0);
      step();
    end
    clr_err = 1'b0;
    idle(40);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
